mem_bus_arbiter: RTL and testbench

//   Shares the single 128-bit slow-memory port between the read-only compressed I-cache and the D-cache.

---
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares the 128-bit slow-memory port between the I-cache and
//               the D-cache, one block transaction at a time. Define ARB_RR_EN
//               for round-robin arbitration; the default is D-priority with a
//               starvation limit for instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    state_t r_state;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;

    assign w_i_req = ic_mem_read;
    assign w_d_req = dc_mem_read | dc_mem_write;

`ifdef ARB_RR_EN
    // r_rr_last = 1 means the last grant went to D, so I wins the next tie.
    logic r_rr_last;

    assign w_grant_i = w_i_req & (~w_d_req | r_rr_last);
`else
    localparam int                 C_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

    logic [C_CNT_W-1:0] r_starve_cnt;

    assign w_grant_i = w_i_req & (~w_d_req | (r_starve_cnt == C_LIMIT));
`endif

    assign w_grant_d = w_d_req & ~w_grant_i;

    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;
    assign ic_mem_ready = mem_ready & (r_state == S_GRANT_I);
    assign dc_mem_ready = mem_ready & (r_state == S_GRANT_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_RR_EN
            r_rr_last <= 1'b0;
`else
            r_starve_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        // A simultaneous read+write is treated as the write-back.
                        r_state   <= S_GRANT_D;
                        mem_write <= dc_mem_write;
                        mem_read  <= ~dc_mem_write;
                        mem_addr  <= dc_mem_addr;
                        mem_wdata <= dc_mem_write ? dc_mem_wdata : '0;
                    end else if (w_grant_i) begin
                        r_state   <= S_GRANT_I;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= ic_mem_addr;
                        mem_wdata <= '0;
                    end else begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                S_GRANT_I, S_GRANT_D: begin
                    if (mem_ready) begin
                        r_state   <= S_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase

`ifdef ARB_RR_EN
            if ((r_state == S_IDLE) && (w_grant_i || w_grant_d))
                r_rr_last <= w_grant_d;
`else
            if (!w_i_req || ((r_state == S_IDLE) && w_grant_i))
                r_starve_cnt <= '0;
            else if ((r_state == S_IDLE) && w_grant_d && (r_starve_cnt != C_LIMIT))
                r_starve_cnt <= r_starve_cnt + C_CNT_W'(1);
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// Directed self-checking bench for mem_bus_arbiter; the memory side is driven
// by hand so every grant and completion happens on a known cycle.
module tb_mem_bus_arbiter;

    localparam int ADDR_W       = 28;
    localparam int DATA_W       = 128;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ic_mem_read;
    logic [ADDR_W-1:0] ic_mem_addr;
    logic [DATA_W-1:0] ic_mem_rdata;
    logic              ic_mem_ready;
    logic              dc_mem_read;
    logic              dc_mem_write;
    logic [ADDR_W-1:0] dc_mem_addr;
    logic [DATA_W-1:0] dc_mem_wdata;
    logic [DATA_W-1:0] dc_mem_rdata;
    logic              dc_mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
        .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
        .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
        .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
        .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ic_mem_read  = 1'b0; ic_mem_addr  = '0;
        dc_mem_read  = 1'b0; dc_mem_write = 1'b0;
        dc_mem_addr  = '0;   dc_mem_wdata = '0;
        mem_rdata    = '0;   mem_ready    = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if ({mem_read, mem_write, ic_mem_ready, dc_mem_ready} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes rd/wr/icr/dcr=%b exp=0000", {mem_read, mem_write, ic_mem_ready, dc_mem_ready}); end
        total++; if (mem_addr !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL reset_bus addr=%h wdata=%h exp=0", mem_addr, mem_wdata); end
        do_reset();
        step();
        total++; if ({mem_read, mem_write} !== 2'b00) begin
            bad++; $display("FAIL idle_no_req rd/wr=%b exp=00", {mem_read, mem_write}); end
    endtask

    task automatic test_i_only();
        do_reset();
        ic_mem_read = 1'b1; ic_mem_addr = 28'h0000010;
        step();
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h10) begin
            bad++; $display("FAIL i_only_grant rd=%b wr=%b addr=%h exp 1 0 10", mem_read, mem_write, mem_addr); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (mem_read !== 1'b1 || ic_mem_ready !== 1'b0) begin
                bad++; $display("FAIL i_only_hold%0d rd=%b icr=%b exp 1 0", k, mem_read, ic_mem_ready); end
        end
        mem_ready = 1'b1; mem_rdata = {4{32'hCAFE_0010}};
        #1;
        total++; if (ic_mem_ready !== 1'b1 || dc_mem_ready !== 1'b0 || ic_mem_rdata !== {4{32'hCAFE_0010}}) begin
            bad++; $display("FAIL i_only_ready icr=%b dcr=%b rdata=%h exp 1 0 cafe", ic_mem_ready, dc_mem_ready, ic_mem_rdata); end
        step();
        mem_ready = 1'b0; ic_mem_read = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0 || ic_mem_ready !== 1'b0) begin
            bad++; $display("FAIL i_only_done rd=%b icr=%b exp 0 0", mem_read, ic_mem_ready); end
        step();
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL i_only_idle rd=%b wr=%b exp 0 0", mem_read, mem_write); end
    endtask

    // First conflict from reset goes to D. D then re-requests straight away:
    // fixed priority serves D again, round-robin hands the bus to I instead.
    task automatic test_conflict();
        logic [ADDR_W-1:0] exp_addr2;
        logic              exp_wr2;
        do_reset();
        ic_mem_read = 1'b1; ic_mem_addr = 28'h20;
        dc_mem_write = 1'b1; dc_mem_addr = 28'h40; dc_mem_wdata = {16{8'hA5}};
        step();
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h40 || mem_wdata !== {16{8'hA5}}) begin
            bad++; $display("FAIL conflict_d_first wr=%b rd=%b addr=%h wdata=%h exp 1 0 40 a5..", mem_write, mem_read, mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        #1;
        total++; if (dc_mem_ready !== 1'b1 || ic_mem_ready !== 1'b0) begin
            bad++; $display("FAIL conflict_d_ready dcr=%b icr=%b exp 1 0", dc_mem_ready, ic_mem_ready); end
        step();
        mem_ready = 1'b0; dc_mem_addr = 28'h41; dc_mem_wdata = {16{8'h5A}};
        step();
`ifdef ARB_RR_EN
        exp_addr2 = 28'h20; exp_wr2 = 1'b0;
`else
        exp_addr2 = 28'h41; exp_wr2 = 1'b1;
`endif
        total++; if (mem_addr !== exp_addr2 || mem_write !== exp_wr2 || mem_read !== ~exp_wr2) begin
            bad++; $display("FAIL conflict_second addr=%h wr=%b rd=%b exp %h %b %b", mem_addr, mem_write, mem_read, exp_addr2, exp_wr2, ~exp_wr2); end
        mem_ready = 1'b1; #1;
        total++; if (ic_mem_ready !== ~exp_wr2 || dc_mem_ready !== exp_wr2) begin
            bad++; $display("FAIL conflict_second_ready icr=%b dcr=%b exp %b %b", ic_mem_ready, dc_mem_ready, ~exp_wr2, exp_wr2); end
        step();
        mem_ready = 1'b0;
        if (exp_wr2) dc_mem_write = 1'b0; else ic_mem_read = 1'b0;
        step();
        total++; if (mem_addr !== (exp_wr2 ? 28'h20 : 28'h41) || mem_write !== ~exp_wr2 || mem_wdata !== (exp_wr2 ? '0 : {16{8'h5A}})) begin
            bad++; $display("FAIL conflict_third addr=%h wr=%b wdata=%h", mem_addr, mem_write, mem_wdata); end
        mem_ready = 1'b1; step(); mem_ready = 1'b0;
        ic_mem_read = 1'b0; dc_mem_write = 1'b0;
    endtask

    task automatic test_starvation();
        int d_grants;
        int exp_d;
        logic got_i;
`ifdef ARB_RR_EN
        exp_d = 1;
`else
        exp_d = STARVE_LIMIT;
`endif
        d_grants = 0; got_i = 1'b0;
        do_reset();
        ic_mem_read = 1'b1; ic_mem_addr = 28'h30;
        dc_mem_read = 1'b1; dc_mem_addr = 28'h50;
        for (int k = 0; k < STARVE_LIMIT + 2 && !got_i; k++) begin
            step();
            if (mem_read === 1'b1 && mem_addr === 28'h50) d_grants++;
            else if (mem_read === 1'b1 && mem_addr === 28'h30) got_i = 1'b1;
            mem_ready = 1'b1; #1;
            if (got_i) begin
                total++; if (ic_mem_ready !== 1'b1 || dc_mem_ready !== 1'b0) begin
                    bad++; $display("FAIL starve_i_ready icr=%b dcr=%b exp 1 0", ic_mem_ready, dc_mem_ready); end
            end
            step();
            mem_ready = 1'b0;
        end
        total++; if (!got_i || d_grants != exp_d) begin
            bad++; $display("FAIL starve_count d_grants=%0d i_granted=%b exp %0d 1", d_grants, got_i, exp_d); end
        ic_mem_read = 1'b0; dc_mem_read = 1'b0;
        step();
    endtask

    task automatic test_rw_both();
        do_reset();
        dc_mem_read = 1'b1; dc_mem_write = 1'b1; dc_mem_addr = 28'h7; dc_mem_wdata = {8{16'h1234}};
        step();
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h7 || mem_wdata !== {8{16'h1234}}) begin
            bad++; $display("FAIL rw_both wr=%b rd=%b addr=%h wdata=%h exp 1 0 7 1234..", mem_write, mem_read, mem_addr, mem_wdata); end
        step();
        mem_ready = 1'b1; #1;
        total++; if (mem_read !== 1'b0 || dc_mem_ready !== 1'b1) begin
            bad++; $display("FAIL rw_both_ready rd=%b dcr=%b exp 0 1", mem_read, dc_mem_ready); end
        step();
        mem_ready = 1'b0; dc_mem_read = 1'b0; dc_mem_write = 1'b0;
        step();
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL rw_both_single rd=%b wr=%b exp 0 0", mem_read, mem_write); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        dc_mem_read = 1'b1; dc_mem_addr = 28'h9;
        step();
        total++; if (mem_read !== 1'b1 || mem_addr !== 28'h9) begin
            bad++; $display("FAIL rst_mid_grant rd=%b addr=%h exp 1 9", mem_read, mem_addr); end
        mem_ready = 1'b1; #1;
        rst_n = 1'b0; #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || dc_mem_ready !== 1'b0 || ic_mem_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_async rd=%b wr=%b dcr=%b icr=%b exp 0", mem_read, mem_write, dc_mem_ready, ic_mem_ready); end
        step();
        mem_ready = 1'b0; dc_mem_read = 1'b0; rst_n = 1'b1;
        ic_mem_read = 1'b1; ic_mem_addr = 28'h11;
        step();
        total++; if (mem_read !== 1'b1 || mem_addr !== 28'h11) begin
            bad++; $display("FAIL rst_mid_fresh rd=%b addr=%h exp 1 11", mem_read, mem_addr); end
        mem_ready = 1'b1; #1;
        total++; if (ic_mem_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_fresh_ready icr=%b exp 1", ic_mem_ready); end
        step();
        mem_ready = 1'b0; ic_mem_read = 1'b0;
    endtask

    task automatic test_drop_mid_grant();
        do_reset();
        ic_mem_read = 1'b1; ic_mem_addr = 28'h22;
        step();
        ic_mem_read = 1'b0; ic_mem_addr = 28'h99;
        step(); step();
        total++; if (mem_read !== 1'b1 || mem_addr !== 28'h22) begin
            bad++; $display("FAIL drop_hold rd=%b addr=%h exp 1 22", mem_read, mem_addr); end
        mem_ready = 1'b1; #1;
        total++; if (ic_mem_ready !== 1'b1 || dc_mem_ready !== 1'b0) begin
            bad++; $display("FAIL drop_ready icr=%b dcr=%b exp 1 0", ic_mem_ready, dc_mem_ready); end
        step();
        mem_ready = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0) begin
            bad++; $display("FAIL drop_done rd=%b exp 0", mem_read); end
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_conflict();
        test_starvation();
        test_rw_both();
        test_reset_mid_grant();
        test_drop_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
